// File: rtl/Pipe_Buf_Reg_PKG.sv
// Shared types and constants for the data-memory arbiter.
package Pipe_Buf_Reg_PKG;

  // Arbiter FSM: serving the core, or holding the port while a debug read is in flight.
  typedef enum logic {
    S_CORE     = 1'b0,
    S_DBG_WAIT = 1'b1
  } arb_state_t;

  // Debug accesses are always full-word.
  localparam logic [2:0] DBG_FUNC3 = 3'b010;

  // Starvation counter width (STARVE_MAX up to 15).
  localparam int STARVE_W = 4;

  // Latency counter width (MEM_LAT up to 3).
  localparam int LAT_W = 2;

endpackage

// File: rtl/rdata_tracker.sv
// Tracks in-flight debug reads through the memory latency and returns their data.
module rdata_tracker #(
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,        // synchronous, active-low
  input  logic              issue_i,      // debug read issued this cycle
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic [MEM_LAT-1:0] vld_q;
  logic [MEM_LAT-1:0] vld_d;
  logic [DATA_W-1:0]  hold_q;

  // Shift a token in on issue; it falls out the top MEM_LAT cycles later.
  always_comb begin
    vld_d    = vld_q << 1;
    vld_d[0] = issue_i;
  end

  // Valid pipeline; reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  // Keep the last returned word so dbg_rdata stays stable after the pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q <= '0;
    end else if (rvalid_o) begin
      hold_q <= mem_rdata_i;
    end
  end

  // Memory data arrives in the completion cycle, so forward it directly then.
  assign rvalid_o = vld_q[MEM_LAT-1];
  assign rdata_o  = rvalid_o ? mem_rdata_i : hold_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single data-memory port between the MEM stage and a debug/loader port.
// Core has priority; a starvation counter forces a debug grant after STARVE_MAX losses.
module dmem_arbiter
  import Pipe_Buf_Reg_PKG::*;
#(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,       // synchronous, active-low
  // MEM stage
  input  logic                  core_rd,
  input  logic                  core_wr,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic                  core_stall,
  output logic [DATA_W-1:0]     core_rdata,
  // Debug / loader
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DM_ADDRESS-1:0] dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,
  // Data memory
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rdata,
  // Observability
  output arb_state_t            arb_state
);

  // Debug handshake: the requester raises dbg_req with stable dbg_we/addr/wdata and
  // holds them until it sees dbg_gnt; the access is issued in the dbg_gnt cycle.
  // A read then returns exactly MEM_LAT cycles later with a one-cycle dbg_rvalid.
  // Dropping dbg_req before a grant withdraws the request.

  localparam logic NEED_WAIT = (MEM_LAT > 1);

  arb_state_t           state_q;
  logic [STARVE_W-1:0]  starve_q;
  logic [LAT_W-1:0]     lat_q;
  logic                 core_req;
  logic                 dbg_rd_issue;

  assign core_req     = core_rd | core_wr;
  assign dbg_rd_issue = dbg_gnt & ~dbg_we;
  assign core_rdata   = mem_rdata;
  assign arb_state    = state_q;

  // Grant decision and memory-port mux; everything is quiet while reset is low.
  always_comb begin
    dbg_gnt    = 1'b0;
    core_stall = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_func3  = '0;
    if (reset) begin
      case (state_q)
        S_CORE: begin
          dbg_gnt = dbg_req &&
                    (!core_req || starve_q == STARVE_W'(STARVE_MAX));
          if (dbg_gnt) begin
            core_stall = core_req;
            mem_rd     = ~dbg_we;
            mem_wr     = dbg_we;
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_func3  = DBG_FUNC3;
          end else if (core_req) begin
            mem_rd     = core_rd;
            mem_wr     = core_wr;
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_func3  = core_func3;
          end
        end
        S_DBG_WAIT: begin
          core_stall = core_req;
        end
        default: ;
      endcase
    end
  end

  // Arbiter FSM with starvation and read-latency counters.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= S_CORE;
      starve_q <= '0;
      lat_q    <= '0;
    end else begin
      if (dbg_gnt || !dbg_req) begin
        starve_q <= '0;
      end else if (starve_q != STARVE_W'(STARVE_MAX)) begin
        starve_q <= starve_q + STARVE_W'(1);
      end

      case (state_q)
        S_CORE: begin
          if (dbg_rd_issue && NEED_WAIT) begin
            state_q <= S_DBG_WAIT;
            lat_q   <= LAT_W'(1);
          end
        end
        S_DBG_WAIT: begin
          if (lat_q == LAT_W'(MEM_LAT - 1)) begin
            state_q <= S_CORE;
            lat_q   <= '0;
          end else begin
            lat_q   <= lat_q + LAT_W'(1);
          end
        end
        default: begin
          state_q <= S_CORE;
          lat_q   <= '0;
        end
      endcase
    end
  end

  rdata_tracker #(
    .DATA_W  (DATA_W),
    .MEM_LAT (MEM_LAT)
  ) u_rdata_tracker (
    .clk         (clk),
    .reset       (reset),
    .issue_i     (dbg_rd_issue),
    .mem_rdata_i (mem_rdata),
    .rvalid_o    (dbg_rvalid),
    .rdata_o     (dbg_rdata)
  );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a MEM_LAT=1 instance driven by a vector table and a
// MEM_LAT=3 instance exercised by hand-written multi-cycle sequences.
module tb_dmem_arbiter;
  import Pipe_Buf_Reg_PKG::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- shared stimulus ----------------
  logic        core_rd, core_wr;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_func3;
  logic        dbg_req, dbg_we;
  logic [8:0]  dbg_addr;
  logic [31:0] dbg_wdata;

  // ---------------- DUT1 (MEM_LAT=1) ----------------
  logic        u1_core_stall, u1_dbg_gnt, u1_dbg_rvalid, u1_mem_rd, u1_mem_wr;
  logic [31:0] u1_core_rdata, u1_dbg_rdata, u1_mem_wdata, m1_rdata;
  logic [8:0]  u1_mem_addr;
  logic [2:0]  u1_mem_func3;
  arb_state_t  u1_state;

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3),
    .core_stall(u1_core_stall), .core_rdata(u1_core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(u1_dbg_gnt), .dbg_rvalid(u1_dbg_rvalid), .dbg_rdata(u1_dbg_rdata),
    .mem_rd(u1_mem_rd), .mem_wr(u1_mem_wr), .mem_addr(u1_mem_addr),
    .mem_wdata(u1_mem_wdata), .mem_func3(u1_mem_func3), .mem_rdata(m1_rdata),
    .arb_state(u1_state)
  );

  // ---------------- DUT3 (MEM_LAT=3) ----------------
  logic        u3_core_stall, u3_dbg_gnt, u3_dbg_rvalid, u3_mem_rd, u3_mem_wr;
  logic [31:0] u3_core_rdata, u3_dbg_rdata, u3_mem_wdata, m3_rdata;
  logic [8:0]  u3_mem_addr;
  logic [2:0]  u3_mem_func3;
  arb_state_t  u3_state;

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3),
    .core_stall(u3_core_stall), .core_rdata(u3_core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(u3_dbg_gnt), .dbg_rvalid(u3_dbg_rvalid), .dbg_rdata(u3_dbg_rdata),
    .mem_rd(u3_mem_rd), .mem_wr(u3_mem_wr), .mem_addr(u3_mem_addr),
    .mem_wdata(u3_mem_wdata), .mem_func3(u3_mem_func3), .mem_rdata(m3_rdata),
    .arb_state(u3_state)
  );

  // ---------------- data-memory models ----------------
  logic [31:0] mem1 [0:511];
  logic [31:0] mem3 [0:511];
  logic [31:0] s1, s3_0, s3_1, s3_2;

  assign m1_rdata = s1;
  assign m3_rdata = s3_2;

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) mem1[i] <= '0;
      s1 <= '0;
    end else begin
      if (u1_mem_wr) mem1[u1_mem_addr] <= u1_mem_wdata;
      s1 <= u1_mem_rd ? mem1[u1_mem_addr] : 32'h0;
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 512; i++) mem3[i] <= '0;
      s3_0 <= '0;
      s3_1 <= '0;
      s3_2 <= '0;
    end else begin
      if (u3_mem_wr) mem3[u3_mem_addr] <= u3_mem_wdata;
      s3_0 <= u3_mem_rd ? mem3[u3_mem_addr] : 32'h0;
      s3_1 <= s3_0;
      s3_2 <= s3_1;
    end
  end

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    string       name;
    logic        rst;
    logic        crd, cwr;
    logic [8:0]  ca;
    logic [31:0] cw;
    logic [2:0]  cf;
    logic        dq, dw;
    logic [8:0]  da;
    logic [31:0] dd;
    logic        es, eg, erd, ewr;
    logic [8:0]  ema;
    logic [31:0] emw;
    logic [2:0]  emf;
    logic        erv;
    logic [31:0] edr;
    logic [31:0] ecr;
  } vec_t;

  vec_t vecs [27];

  function automatic vec_t mkv(
    input string n, input logic rst,
    input logic crd, input logic cwr, input logic [8:0] ca, input logic [31:0] cw,
    input logic [2:0] cf,
    input logic dq, input logic dw, input logic [8:0] da, input logic [31:0] dd,
    input logic es, input logic eg, input logic erd, input logic ewr,
    input logic [8:0] ema, input logic [31:0] emw, input logic [2:0] emf,
    input logic erv, input logic [31:0] edr, input logic [31:0] ecr);
    vec_t v;
    v.name = n;  v.rst = rst;
    v.crd = crd; v.cwr = cwr; v.ca = ca; v.cw = cw; v.cf = cf;
    v.dq = dq;   v.dw = dw;   v.da = da; v.dd = dd;
    v.es = es;   v.eg = eg;   v.erd = erd; v.ewr = ewr;
    v.ema = ema; v.emw = emw; v.emf = emf;
    v.erv = erv; v.edr = edr; v.ecr = ecr;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic crd, input logic cwr, input logic [8:0] ca,
                        input logic [31:0] cw, input logic [2:0] cf,
                        input logic dq, input logic dw, input logic [8:0] da,
                        input logic [31:0] dd);
    @(negedge clk);
    core_rd = crd; core_wr = cwr; core_addr = ca; core_wdata = cw; core_func3 = cf;
    dbg_req = dq;  dbg_we = dw;   dbg_addr = da;  dbg_wdata = dd;
    #1;
  endtask

  task automatic apply_row(input vec_t v);
    @(negedge clk);
    reset   = v.rst;
    core_rd = v.crd; core_wr = v.cwr; core_addr = v.ca; core_wdata = v.cw; core_func3 = v.cf;
    dbg_req = v.dq;  dbg_we = v.dw;   dbg_addr = v.da;  dbg_wdata = v.dd;
    #1;
    chk({v.name, ".core_stall"}, 32'(u1_core_stall), 32'(v.es));
    chk({v.name, ".dbg_gnt"},    32'(u1_dbg_gnt),    32'(v.eg));
    chk({v.name, ".mem_rd"},     32'(u1_mem_rd),     32'(v.erd));
    chk({v.name, ".mem_wr"},     32'(u1_mem_wr),     32'(v.ewr));
    chk({v.name, ".mem_addr"},   32'(u1_mem_addr),   32'(v.ema));
    chk({v.name, ".mem_wdata"},  u1_mem_wdata,       v.emw);
    chk({v.name, ".mem_func3"},  32'(u1_mem_func3),  32'(v.emf));
    chk({v.name, ".dbg_rvalid"}, 32'(u1_dbg_rvalid), 32'(v.erv));
    chk({v.name, ".dbg_rdata"},  u1_dbg_rdata,       v.edr);
    chk({v.name, ".core_rdata"}, u1_core_rdata,      v.ecr);
  endtask

  // ---------------- test ----------------
  initial begin
    reset = 1'b0;
    core_rd = 1'b0; core_wr = 1'b0; core_addr = '0; core_wdata = '0; core_func3 = '0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9'h010; dbg_wdata = '0;

    // Reset with a pending debug request, then debug write / read, core store / debug read.
    vecs[0]  = mkv("rst_a", 0, 0,0,9'h000,32'h0,3'b000, 1,0,9'h010,32'h0,
                   0,0,0,0,9'h000,32'h0,3'b000, 0,32'h0,32'h0);
    vecs[1]  = mkv("rst_b", 0, 0,0,9'h000,32'h0,3'b000, 1,0,9'h010,32'h0,
                   0,0,0,0,9'h000,32'h0,3'b000, 0,32'h0,32'h0);
    vecs[2]  = mkv("dbg_wr", 1, 0,0,9'h000,32'h0,3'b000, 1,1,9'h010,32'hDEADBEEF,
                   0,1,0,1,9'h010,32'hDEADBEEF,3'b010, 0,32'h0,32'h0);
    vecs[3]  = mkv("wr_idle", 1, 0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0,
                   0,0,0,0,9'h000,32'h0,3'b000, 0,32'h0,32'h0);
    vecs[4]  = mkv("dbg_rd", 1, 0,0,9'h000,32'h0,3'b000, 1,0,9'h010,32'h0,
                   0,1,1,0,9'h010,32'h0,3'b010, 0,32'h0,32'h0);
    vecs[5]  = mkv("rd_done", 1, 0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0,
                   0,0,0,0,9'h000,32'h0,3'b000, 1,32'hDEADBEEF,32'hDEADBEEF);
    vecs[6]  = mkv("rd_hold", 1, 0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0,
                   0,0,0,0,9'h000,32'h0,3'b000, 0,32'hDEADBEEF,32'h0);
    vecs[7]  = mkv("core_sw", 1, 0,1,9'h020,32'h55,3'b010, 0,0,9'h000,32'h0,
                   0,0,0,1,9'h020,32'h55,3'b010, 0,32'hDEADBEEF,32'h0);
    vecs[8]  = mkv("dbg_rd2", 1, 0,0,9'h000,32'h0,3'b000, 1,0,9'h020,32'h0,
                   0,1,1,0,9'h020,32'h0,3'b010, 0,32'hDEADBEEF,32'h0);
    vecs[9]  = mkv("rd2_done", 1, 0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0,
                   0,0,0,0,9'h000,32'h0,3'b000, 1,32'h55,32'h55);
    // Continuous core loads against a held debug read: four core wins, then forced grant.
    for (int i = 10; i < 14; i++)
      vecs[i] = mkv("starve", 1, 1,0,9'h030,32'h0,3'b100, 1,0,9'h010,32'h0,
                    0,0,1,0,9'h030,32'h0,3'b100, 0,32'h55,32'h0);
    vecs[14] = mkv("starve_gnt", 1, 1,0,9'h030,32'h0,3'b100, 1,0,9'h010,32'h0,
                   1,1,1,0,9'h010,32'h0,3'b010, 0,32'h55,32'h0);
    vecs[15] = mkv("core_resume", 1, 1,0,9'h030,32'h0,3'b100, 0,0,9'h000,32'h0,
                   0,0,1,0,9'h030,32'h0,3'b100, 1,32'hDEADBEEF,32'hDEADBEEF);
    vecs[16] = mkv("idle2", 1, 0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0,
                   0,0,0,0,9'h000,32'h0,3'b000, 0,32'hDEADBEEF,32'h0);
    // Withdrawn request clears the starvation count: a full four losses are needed again.
    for (int i = 17; i < 20; i++)
      vecs[i] = mkv("pre_drop", 1, 1,0,9'h030,32'h0,3'b100, 1,0,9'h010,32'h0,
                    0,0,1,0,9'h030,32'h0,3'b100, 0,32'hDEADBEEF,32'h0);
    vecs[20] = mkv("drop", 1, 1,0,9'h030,32'h0,3'b100, 0,0,9'h000,32'h0,
                   0,0,1,0,9'h030,32'h0,3'b100, 0,32'hDEADBEEF,32'h0);
    for (int i = 21; i < 25; i++)
      vecs[i] = mkv("post_drop", 1, 1,0,9'h030,32'h0,3'b100, 1,0,9'h010,32'h0,
                    0,0,1,0,9'h030,32'h0,3'b100, 0,32'hDEADBEEF,32'h0);
    vecs[25] = mkv("post_gnt", 1, 1,0,9'h030,32'h0,3'b100, 1,0,9'h010,32'h0,
                   1,1,1,0,9'h010,32'h0,3'b010, 0,32'hDEADBEEF,32'h0);
    vecs[26] = mkv("post_done", 1, 0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0,
                   0,0,0,0,9'h000,32'h0,3'b000, 1,32'hDEADBEEF,32'hDEADBEEF);

    for (int i = 0; i < 27; i++) apply_row(vecs[i]);

    // Let the MEM_LAT=3 instance drain to an idle S_CORE.
    for (int i = 0; i < 4; i++) set_in(0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0);

    // MEM_LAT=3: preload 0x060, then debug read under a held core store.
    set_in(0,0,9'h000,32'h0,3'b000, 1,1,9'h060,32'hA5A50003);
    chk("l3_preload.dbg_gnt",  32'(u3_dbg_gnt), 32'd1);
    chk("l3_preload.mem_wr",   32'(u3_mem_wr),  32'd1);
    chk("l3_preload.mem_addr", 32'(u3_mem_addr), 32'h060);
    set_in(0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0);

    for (int i = 0; i < 4; i++) begin
      set_in(0,1,9'h070,32'h77,3'b010, 1,0,9'h060,32'h0);
      chk("l3_core_win.core_stall", 32'(u3_core_stall), 32'd0);
      chk("l3_core_win.dbg_gnt",    32'(u3_dbg_gnt),    32'd0);
      chk("l3_core_win.mem_addr",   32'(u3_mem_addr),   32'h070);
    end
    set_in(0,1,9'h070,32'h77,3'b010, 1,0,9'h060,32'h0);
    chk("l3_gnt.core_stall", 32'(u3_core_stall), 32'd1);
    chk("l3_gnt.dbg_gnt",    32'(u3_dbg_gnt),    32'd1);
    chk("l3_gnt.mem_rd",     32'(u3_mem_rd),     32'd1);
    chk("l3_gnt.mem_wr",     32'(u3_mem_wr),     32'd0);
    chk("l3_gnt.mem_addr",   32'(u3_mem_addr),   32'h060);
    chk("l3_gnt.mem_func3",  32'(u3_mem_func3),  32'h2);
    for (int i = 0; i < 2; i++) begin
      set_in(0,1,9'h070,32'h77,3'b010, 0,0,9'h000,32'h0);
      chk("l3_wait.core_stall", 32'(u3_core_stall), 32'd1);
      chk("l3_wait.mem_wr",     32'(u3_mem_wr),     32'd0);
      chk("l3_wait.mem_rd",     32'(u3_mem_rd),     32'd0);
      chk("l3_wait.mem_addr",   32'(u3_mem_addr),   32'h0);
      chk("l3_wait.dbg_rvalid", 32'(u3_dbg_rvalid), 32'd0);
      chk("l3_wait.state",      32'(u3_state),      32'(S_DBG_WAIT));
    end
    set_in(0,1,9'h070,32'h77,3'b010, 0,0,9'h000,32'h0);
    chk("l3_done.core_stall", 32'(u3_core_stall), 32'd0);
    chk("l3_done.mem_wr",     32'(u3_mem_wr),     32'd1);
    chk("l3_done.mem_addr",   32'(u3_mem_addr),   32'h070);
    chk("l3_done.mem_wdata",  u3_mem_wdata,       32'h77);
    chk("l3_done.dbg_rvalid", 32'(u3_dbg_rvalid), 32'd1);
    chk("l3_done.dbg_rdata",  u3_dbg_rdata,       32'hA5A50003);
    set_in(0,0,9'h000,32'h0,3'b000, 0,0,9'h000,32'h0);
    chk("l3_after.dbg_rvalid", 32'(u3_dbg_rvalid), 32'd0);
    chk("l3_after.dbg_rdata",  u3_dbg_rdata,       32'hA5A50003);

    // MEM_LAT=3: reset while a debug read is pending abandons it.
    set_in(0,0,9'h000,32'h0,3'b000, 1,0,9'h060,32'h0);
    chk("l3_rst_gnt.dbg_gnt", 32'(u3_dbg_gnt), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    core_rd = 1'b0; core_wr = 1'b0; dbg_req = 1'b0;
    #1;
    chk("l3_in_rst.dbg_gnt", 32'(u3_dbg_gnt), 32'd0);
    chk("l3_in_rst.mem_rd",  32'(u3_mem_rd),  32'd0);
    @(negedge clk);
    reset = 1'b1;
    core_rd = 1'b1; core_addr = 9'h070; core_func3 = 3'b010;
    #1;
    chk("l3_post_rst.state",      32'(u3_state),      32'(S_CORE));
    chk("l3_post_rst.core_stall", 32'(u3_core_stall), 32'd0);
    chk("l3_post_rst.mem_rd",     32'(u3_mem_rd),     32'd1);
    chk("l3_post_rst.mem_addr",   32'(u3_mem_addr),   32'h070);
    chk("l3_post_rst.dbg_rvalid", 32'(u3_dbg_rvalid), 32'd0);
    chk("l3_post_rst.dbg_rdata",  u3_dbg_rdata,       32'h0);
    for (int i = 0; i < 3; i++) begin
      set_in(1,0,9'h070,32'h0,3'b010, 0,0,9'h000,32'h0);
      chk("l3_no_rvalid", 32'(u3_dbg_rvalid), 32'd0);
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
